// File: rtl/spi_tx_pkg.sv
// Shared types and constants for the SPI byte transmitter.
// Holds the FSM state encoding, byte/bit widths and divider width.
package spi_tx_pkg;

    localparam int BYTE_W    = 8;
    localparam int BIT_CNT_W = 3;
    localparam int DIV_W     = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

endpackage

// File: rtl/spi_byte_tx_if.sv
// Byte-in / SPI-out bundle between the FIFO reader and spi_byte_tx.
// master: drives data_in/send; slave: drives done, busy, SPI pins, status.
interface spi_byte_tx_if
    import spi_tx_pkg::*;
#(
    parameter int CNT_W = 16
) ();

    logic [BYTE_W-1:0] data_in;
    logic              send;
    logic              done;
    logic              busy;
    logic              sclk;
    logic              mosi;
    logic              cs_n;
    logic              overrun;
    logic [CNT_W-1:0]  byte_cnt;

    modport master (
        output data_in, send,
        input  done, busy, sclk, mosi, cs_n, overrun, byte_cnt
    );

    modport slave (
        input  data_in, send,
        output done, busy, sclk, mosi, cs_n, overrun, byte_cnt
    );

endinterface

// File: rtl/spi_tick_div.sv
// Down-counting phase timer: tick_o pulses on the last cycle of a phase.
// Ports: clk_i, rst_i (sync, high), clr_i (hold at load), load_i, tick_o.
module spi_tick_div
    import spi_tx_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] load_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // load_i is the length of the phase that starts on this edge, so
    // a phase of L cycles ticks in its L-th cycle.
    assign tick_o = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (clr_i || tick_o) begin
            cnt_d = load_i - 1'b1;
        end
    end

    // Reset leaves the counter expired so the current phase ends at once.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_byte_tx.sv
// SPI mode-0 master sending one byte per send strobe, MSB first.
// Ports: clk_out1, rst (sync, high), bus (slave side of spi_byte_tx_if).
module spi_byte_tx
    import spi_tx_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 4,
    parameter int CNT_W   = 16
) (
    input  logic          clk_out1,
    input  logic          rst,
    spi_byte_tx_if.slave  bus
);

    localparam logic [DIV_W-1:0] HALF_LEN = DIV_W'(CLK_DIV);
    localparam logic [DIV_W-1:0] GAP_LEN  = DIV_W'(CS_GAP);

    state_t                state_q;
    state_t                state_d;
    logic                  sclk_q;
    logic                  sclk_d;
    logic                  cs_n_q;
    logic                  cs_n_d;
    logic                  done_q;
    logic                  done_d;
    logic                  ovr_q;
    logic                  ovr_d;
    logic [BYTE_W-1:0]     sh_q;
    logic [BYTE_W-1:0]     sh_d;
    logic [BIT_CNT_W-1:0]  bit_q;
    logic [BIT_CNT_W-1:0]  bit_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;

    logic                  tick;
    logic                  div_clr;
    logic [DIV_W-1:0]      div_load;

    // The divider is parked in IDLE; every other phase is CLK_DIV long
    // except GAP.
    assign div_clr  = (state_q == IDLE);
    assign div_load = (state_d == GAP) ? GAP_LEN : HALF_LEN;

    spi_tick_div u_div (
        .clk_i  (clk_out1),
        .rst_i  (rst),
        .clr_i  (div_clr),
        .load_i (div_load),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q | (bus.send & (state_q != IDLE));

        unique case (state_q)
            IDLE: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                if (bus.send) begin
                    sh_d    = bus.data_in;
                    cs_n_d  = 1'b0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    bit_d   = BIT_CNT_W'(BYTE_W - 1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        // mosi is sh_q MSB, so it only moves on the
                        // falling edge; the last bit stays through HOLD.
                        if (bit_q == '0) begin
                            state_d = HOLD;
                        end else begin
                            bit_d = bit_q - 1'b1;
                            sh_d  = {sh_q[BYTE_W-2:0], 1'b0};
                        end
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    cs_n_d  = 1'b1;
                    sh_d    = '0;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = GAP;
            end
        endcase
    end

    // Reset parks in GAP with the divider expired, so the first edge
    // out of reset lands in IDLE and emits done.
    always_ff @(posedge clk_out1) begin
        if (rst) begin
            state_q <= GAP;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            sh_q    <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.done     = done_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.sclk     = sclk_q;
    assign bus.mosi     = sh_q[BYTE_W-1];
    assign bus.cs_n     = cs_n_q;
    assign bus.overrun  = ovr_q;
    assign bus.byte_cnt = cnt_q;

endmodule

// File: tb/tb_spi_byte_tx.sv
// Directed + random bench for spi_byte_tx, default and fast configs.
// Frames are checked against byte value, timing and count rules.
module tb_spi_byte_tx;

    localparam int DA    = 2;
    localparam int GA    = 4;
    localparam int DB    = 1;
    localparam int GB    = 1;
    localparam int LAT_A = 18 * DA + GA + 1;
    localparam int LAT_B = 18 * DB + GB + 1;

    logic clk;
    logic rst_a;
    logic rst_b;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int stray_a = 0;
    int stray_b = 0;

    logic q_a[$];
    logic q_b[$];
    int   t_b[$];

    spi_byte_tx_if #(.CNT_W(16)) ia ();
    spi_byte_tx_if #(.CNT_W(2))  ib ();

    spi_byte_tx #(.CLK_DIV(DA), .CS_GAP(GA), .CNT_W(16)) dut_a (
        .clk_out1 (clk),
        .rst      (rst_a),
        .bus      (ia)
    );

    spi_byte_tx #(.CLK_DIV(DB), .CS_GAP(GB), .CNT_W(2)) dut_b (
        .clk_out1 (clk),
        .rst      (rst_b),
        .bus      (ib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave-side view: mosi sampled on each sclk rise.
    always @(posedge ia.sclk) begin
        q_a.push_back(ia.mosi);
        if (ia.cs_n !== 1'b0) stray_a++;
    end

    always @(posedge ib.sclk) begin
        q_b.push_back(ib.mosi);
        t_b.push_back(cyc);
        if (ib.cs_n !== 1'b0) stray_b++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pack_a();
        logic [7:0] v = '0;
        for (int i = 0; i < q_a.size() && i < 8; i++) v[7-i] = q_a[i];
        return v;
    endfunction

    function automatic logic [7:0] pack_b();
        logic [7:0] v = '0;
        for (int i = 0; i < q_b.size() && i < 8; i++) v[7-i] = q_b[i];
        return v;
    endfunction

    // Called at a falling clk edge with dut_a in IDLE. lat counts cycles
    // after the accept edge (1 = first); ends at the sample with done=1.
    task automatic frame_a(input logic [7:0] v, input int pulse_at,
                           input logic [7:0] pv, output int lat,
                           output int lo, output int hi);
        q_a.delete();
        ia.data_in = v;
        ia.send    = 1'b1;
        lo = 0;
        hi = 0;
        @(negedge clk);
        ia.send = 1'b0;
        lat = 1;
        while (ia.done !== 1'b1 && lat < 200) begin
            if (ia.cs_n === 1'b0) lo++;
            else hi++;
            if (lat == pulse_at) begin
                ia.send    = 1'b1;
                ia.data_in = pv;
            end else begin
                ia.send    = 1'b0;
                ia.data_in = 8'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        ia.send = 1'b0;
    endtask

    task automatic frame_b(input logic [7:0] v, output int lat);
        q_b.delete();
        t_b.delete();
        ib.data_in = v;
        ib.send    = 1'b1;
        @(negedge clk);
        ib.send = 1'b0;
        lat = 1;
        while (ib.done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int          lat;
        int          lo;
        int          hi;
        int          k;
        int          nb;
        logic [7:0]  v;
        logic [15:0] exp_a;
        logic [1:0]  exp_b;
        logic [7:0]  bb [3];

        bb = '{8'h00, 8'hFF, 8'h3C};
        exp_a = '0;
        exp_b = '0;
        ia.send = 1'b0;
        ia.data_in = '0;
        ib.send = 1'b0;
        ib.data_in = '0;
        rst_a = 1'b1;
        rst_b = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", ia.busy, 1);
        chk("rst_done", ia.done, 0);
        chk("rst_cs_n", ia.cs_n, 1);
        chk("rst_sclk", ia.sclk, 0);
        chk("rst_mosi", ia.mosi, 0);
        chk("rst_ovr", ia.overrun, 0);
        chk("rst_cnt", ia.byte_cnt, 0);

        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        chk("first_done", ia.done, 1);
        chk("first_busy", ia.busy, 0);
        chk("first_cs_n", ia.cs_n, 1);
        chk("first_sclk", ia.sclk, 0);
        chk("first_done_b", ib.done, 1);
        @(negedge clk);
        chk("done_pulse", ia.done, 0);

        frame_a(8'hA5, 0, 8'h00, lat, lo, hi);
        exp_a++;
        chk("a5_lat", lat, LAT_A);
        chk("a5_cs_lo", lo, 18 * DA);
        chk("a5_cs_hi", hi, GA);
        chk("a5_nbits", q_a.size(), 8);
        chk("a5_bits", pack_a(), 8'hA5);
        chk("a5_cnt", ia.byte_cnt, exp_a);

        for (int i = 0; i < 3; i++) begin
            frame_a(bb[i], 0, 8'h00, lat, lo, hi);
            exp_a++;
            chk("b2b_lat", lat, LAT_A);
            chk("b2b_gap", hi, GA);
            chk("b2b_bits", pack_a(), bb[i]);
            chk("b2b_cnt", ia.byte_cnt, exp_a);
        end
        chk("b2b_ovr", ia.overrun, 0);

        frame_a(8'h81, 10, 8'h7E, lat, lo, hi);
        exp_a++;
        chk("ovr_lat", lat, LAT_A);
        chk("ovr_bits", pack_a(), 8'h81);
        chk("ovr_flag", ia.overrun, 1);
        chk("ovr_cnt", ia.byte_cnt, exp_a);
        repeat (5) @(negedge clk);
        chk("ovr_idle", ia.busy, 0);
        chk("ovr_nbits", q_a.size(), 8);
        chk("ovr_sticky", ia.overrun, 1);

        repeat (6) begin
            v = 8'($urandom);
            frame_a(v, 0, 8'h00, lat, lo, hi);
            exp_a++;
            chk("rnd_lat", lat, LAT_A);
            chk("rnd_bits", pack_a(), v);
            chk("rnd_cnt", ia.byte_cnt, exp_a);
        end

        q_a.delete();
        ia.data_in = 8'hF0;
        ia.send    = 1'b1;
        @(negedge clk);
        ia.send = 1'b0;
        k = 0;
        while (q_a.size() < 5 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("mid_reach", q_a.size(), 5);
        chk("mid_bits", pack_a(), 8'hF0 & 8'hF8);
        rst_a = 1'b1;
        @(negedge clk);
        exp_a = '0;
        chk("mid_cs_n", ia.cs_n, 1);
        chk("mid_sclk", ia.sclk, 0);
        chk("mid_mosi", ia.mosi, 0);
        chk("mid_busy", ia.busy, 1);
        chk("mid_ovr", ia.overrun, 0);
        chk("mid_cnt", ia.byte_cnt, exp_a);
        rst_a = 1'b0;
        @(negedge clk);
        chk("mid_done", ia.done, 1);
        nb = q_a.size();
        repeat (20) @(negedge clk);
        chk("mid_nosclk", q_a.size(), nb);

        v = 8'($urandom);
        frame_a(v, 0, 8'h00, lat, lo, hi);
        exp_a++;
        chk("post_bits", pack_a(), v);
        chk("post_cnt", ia.byte_cnt, exp_a);

        for (int i = 0; i < 5; i++) begin
            v = (i == 0) ? 8'h5A : 8'($urandom);
            frame_b(v, lat);
            exp_b++;
            chk("fast_lat", lat, LAT_B);
            chk("fast_bits", pack_b(), v);
            if (i == 0 && t_b.size() >= 2)
                chk("fast_period", t_b[1] - t_b[0], 2 * DB);
        end
        chk("fast_cnt", ib.byte_cnt, exp_b);
        chk("fast_ovr", ib.overrun, 0);

        chk("stray_a", stray_a, 0);
        chk("stray_b", stray_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_byte_tx.md
Name: spi_byte_tx

Overview:
- SPI master transmitter that drains the FIFO buffering block downstream of the filter, one byte at a time.
- Accepts an 8-bit byte with a one-cycle `send` strobe.
- Shifts the byte out MSB-first in SPI mode 0 (CPOL=0, CPHA=0) with a framed chip-select.
- Returns a one-cycle `done` pulse when it is ready for the next byte; this pulse is the buffering block's read trigger.

Parameters:
- CLK_DIV, 2, clk_out1 cycles per SCLK half-period; legal range 1..255.
- CS_GAP, 4, clk_out1 cycles cs_n is held high between frames; legal range 1..255.
- CNT_W, 16, width of the transmitted-byte counter.

Ports:
- clk_out1  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  8  byte to transmit; sampled only on the accepting edge.
- send  input  1  transmit request strobe; honoured only in IDLE.
- done  output  1  one-cycle pulse: transmitter has just entered IDLE and is ready.
- busy  output  1  high in every state except IDLE.
- sclk  output  1  SPI clock, idles low.
- mosi  output  1  SPI data out.
- cs_n  output  1  SPI chip select, active low.
- overrun  output  1  sticky flag: `send` was seen while busy; cleared only by rst.
- byte_cnt  output  CNT_W  count of completed frames; wraps modulo 2^CNT_W.

Behaviour:
- Reset values, applied on any edge with rst=1, including mid-frame:
  - sclk=0, mosi=0, cs_n=1, busy=1, done=0, overrun=0, byte_cnt=0.
  - State goes to GAP with its counter preloaded so GAP expires immediately.
  - A frame cut by reset is abandoned; cs_n rises on that same edge.
- First done pulse: on the first edge with rst=0, the FSM enters IDLE. done=1 and busy=0 for the following cycle. This kicks off the upstream reader.
- FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE:
  - cs_n=1, sclk=0.
  - On an edge where send=1: latch data_in into the shift register, go to SETUP, drive cs_n=0 and mosi=data_in[7].
- SETUP: hold for CLK_DIV cycles with sclk=0, then go to SHIFT.
- SHIFT: 8 bits, each bit being CLK_DIV cycles with sclk=0 followed by CLK_DIV cycles with sclk=1.
  - mosi changes only on the edge that drives sclk 1->0, i.e. the SCLK falling edge.
  - Bit order is 7 down to 0.
  - After bit 0's high phase, sclk=0 and the FSM goes to HOLD.
- HOLD:
  - CLK_DIV cycles with cs_n=0 and sclk=0.
  - Then cs_n=1, mosi=0, byte_cnt+1, go to GAP.
- GAP: CS_GAP cycles with cs_n=1, then IDLE with done=1 for exactly one cycle.
- Latency:
  - done is asserted exactly 18*CLK_DIV+CS_GAP+1 cycles after the send-accepting edge.
  - For defaults (CLK_DIV=2, CS_GAP=4) this is 41 cycles.
- Frame shape: exactly 8 rising sclk edges per frame, none outside cs_n=0.
- Simultaneous done and send: send in the same cycle that done=1 is accepted (the FSM is in IDLE).
- send while busy: ignored, frame undisturbed, overrun set to 1.
- send held high in IDLE for several cycles: only the first edge starts a frame. On later cycles the FSM is no longer in IDLE, so those cycles set overrun.
- data_in changes during a frame: no effect.
- byte_cnt at 2^CNT_W-1: wraps to 0 on the next completed frame.

Decomposition:
- Package spi_tx_pkg holds:
  - the state enum (IDLE, SETUP, SHIFT, HOLD, GAP);
  - the BYTE_W=8 and BIT_CNT_W=3 constants;
  - the divider counter width of 8 bits.
- One sub-module, spi_tick_div:
  - Counts clk_out1 cycles against a load value.
  - Emits a one-cycle tick when the count expires.
  - Inputs: clear and load value. Used for the SETUP, half-bit, HOLD and GAP timing.
- FSM, shift register, overrun and byte_cnt logic stay in spi_byte_tx.

Test Plan:
- Reset release: rst high 3 cycles then low -> done=1 exactly one cycle after the first rst=0 edge; cs_n=1, sclk=0, busy=0, byte_cnt=0.
- Single byte: send with data_in=8'hA5 (defaults) -> mosi sampled on the 8 sclk rising edges reads 1,0,1,0,0,1,0,1; cs_n low for 18*2=36 cycles; done 41 cycles after accept; byte_cnt=1.
- Back-to-back: send asserted in each done cycle with 8'h00, 8'hFF, 8'h3C -> three frames, each 41 cycles apart; no overrun; byte_cnt=3; CS_GAP=4 cycles of cs_n high between frames.
- Overrun: send 8'h81, then pulse send with 8'h7E at cycle 10 of the frame -> frame still shifts 8'h81; overrun=1 and stays 1; byte_cnt=1; only one frame observed.
- Reset mid-frame: assert rst at bit 3 of 8'hF0 -> cs_n=1, sclk=0, mosi=0 on that edge; no further sclk edges; done one cycle after the first rst=0 edge; byte_cnt=0.
- Parameter sweep: CLK_DIV=1, CS_GAP=1 with 8'h5A -> correct bits; done 20 cycles after accept; sclk period 2 cycles. With CNT_W=2, 5 frames -> byte_cnt=1.
